// File: rtl/ttm4_mem_pkg.sv
// Shared definitions for the TTM4 program-memory arbiter: default widths,
// phase encodings and instruction-word field positions.
package ttm4_mem_pkg;

    localparam int unsigned TTM4_AW = 8;
    localparam int unsigned TTM4_DW = 15;

    localparam int unsigned OP_MSB = 14;
    localparam int unsigned OP_LSB = 10;
    localparam int unsigned SR_MSB = 9;
    localparam int unsigned SR_LSB = 7;
    localparam int unsigned LR_MSB = 6;
    localparam int unsigned LR_LSB = 4;
    localparam int unsigned IM_MSB = 3;
    localparam int unsigned IM_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } arb_state_e;

    // Assemble an instruction word from its OP/SR/LR/IM fields.
    function automatic logic [TTM4_DW-1:0] ttm4_word(input logic [4:0] op, input logic [2:0] sr,
                                                     input logic [2:0] lr, input logic [3:0] im);
        logic [TTM4_DW-1:0] w;
        w                 = '0;
        w[OP_MSB:OP_LSB]  = op;
        w[SR_MSB:SR_LSB]  = sr;
        w[LR_MSB:LR_LSB]  = lr;
        w[IM_MSB:IM_LSB]  = im;
        return w;
    endfunction

endpackage

// File: rtl/ttm4_mem_arbiter.sv
// Round-robin arbiter between CPU fetch and loader port for the TTM4 program
// memory; sequences each access through SETUP/STROBE/HOLD with registered strobes.
module ttm4_mem_arbiter
    import ttm4_mem_pkg::*;
#(
    parameter int unsigned AW         = TTM4_AW,
    parameter int unsigned DW         = TTM4_DW,
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 1,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          F_REQ,
    input  logic [AW-1:0] F_ADD,
    output logic          F_ACK,
    output logic [DW-1:0] F_RDATA,
    input  logic          L_REQ,
    input  logic          L_WE,
    input  logic [AW-1:0] L_ADD,
    input  logic [DW-1:0] L_WDATA,
    output logic          L_ACK,
    output logic [DW-1:0] L_RDATA,
    output logic          nOE,
    output logic          nWE,
    output logic [AW-1:0] ADD,
    output logic [DW-1:0] WDATA,
    output logic          WDATA_OE,
    input  logic [DW-1:0] RDATA,
    output logic          BUSY,
    output logic          GRANT
);

    localparam int unsigned MAX_SS  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int unsigned MAX_CYC = (MAX_SS > HOLD_CYC) ? MAX_SS : HOLD_CYC;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC - 1);

    if (SETUP_CYC < 1 || STROBE_CYC < 1 || HOLD_CYC < 1) begin : g_bad_cfg
        $error("ttm4_mem_arbiter: SETUP_CYC, STROBE_CYC and HOLD_CYC must all be >= 1");
    end

    arb_state_e    state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          last_owner, last_owner_nx;
    logic          acc_we, acc_we_nx;
    logic          pick_l;
    logic          ack_nx;
    logic          noe_nx, nwe_nx, wdata_oe_nx, busy_nx, grant_nx;
    logic          f_ack_nx, l_ack_nx;
    logic [AW-1:0] add_nx;
    logic [DW-1:0] wdata_nx, f_rdata_nx, l_rdata_nx;

    // State, phase counter and every output are registered together.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            last_owner <= 1'b1;
            acc_we     <= 1'b0;
            nOE        <= 1'b1;
            nWE        <= 1'b1;
            ADD        <= '0;
            WDATA      <= '0;
            WDATA_OE   <= 1'b0;
            F_ACK      <= 1'b0;
            L_ACK      <= 1'b0;
            F_RDATA    <= '0;
            L_RDATA    <= '0;
            BUSY       <= 1'b0;
            GRANT      <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            last_owner <= last_owner_nx;
            acc_we     <= acc_we_nx;
            nOE        <= noe_nx;
            nWE        <= nwe_nx;
            ADD        <= add_nx;
            WDATA      <= wdata_nx;
            WDATA_OE   <= wdata_oe_nx;
            F_ACK      <= f_ack_nx;
            L_ACK      <= l_ack_nx;
            F_RDATA    <= f_rdata_nx;
            L_RDATA    <= l_rdata_nx;
            BUSY       <= busy_nx;
            GRANT      <= grant_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        last_owner_nx = last_owner;
        acc_we_nx     = acc_we;
        add_nx        = ADD;
        wdata_nx      = WDATA;
        wdata_oe_nx   = WDATA_OE;
        grant_nx      = GRANT;
        f_rdata_nx    = F_RDATA;
        l_rdata_nx    = L_RDATA;
        noe_nx        = 1'b1;
        nwe_nx        = 1'b1;
        // On a tie the loader wins only if fetch owned the previous access.
        pick_l        = L_REQ && (!F_REQ || !last_owner);

        unique case (state)
            ST_IDLE: begin
                if (F_REQ || L_REQ) begin
                    state_nx      = ST_SETUP;
                    cnt_nx        = SETUP_LD;
                    grant_nx      = pick_l;
                    last_owner_nx = pick_l;
                    acc_we_nx     = pick_l && L_WE;
                    add_nx        = pick_l ? L_ADD : F_ADD;
                    wdata_oe_nx   = pick_l && L_WE;
                    if (pick_l && L_WE) wdata_nx = L_WDATA;
                end
            end
            ST_SETUP: begin
                if (cnt == '0) begin
                    state_nx = ST_STROBE;
                    cnt_nx   = STROBE_LD;
                    noe_nx   = acc_we;
                    nwe_nx   = !acc_we;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            ST_STROBE: begin
                if (cnt == '0) begin
                    state_nx = ST_HOLD;
                    cnt_nx   = HOLD_LD;
                    if (!acc_we) begin
                        if (GRANT) l_rdata_nx = RDATA;
                        else       f_rdata_nx = RDATA;
                    end
                end else begin
                    cnt_nx = cnt - CW'(1);
                    noe_nx = acc_we;
                    nwe_nx = !acc_we;
                end
            end
            ST_HOLD: begin
                if (cnt == '0) begin
                    state_nx    = ST_IDLE;
                    wdata_oe_nx = 1'b0;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            default: state_nx = ST_IDLE;
        endcase

        ack_nx   = (state_nx == ST_HOLD) && (cnt_nx == '0);
        f_ack_nx = ack_nx && !GRANT;
        l_ack_nx = ack_nx && GRANT;
        busy_nx  = (state_nx != ST_IDLE);
    end

endmodule

// File: tb/tb_ttm4_mem_arbiter.sv
// Scoreboard bench for ttm4_mem_arbiter: directed accesses push expected ACKs,
// a negedge monitor pops and checks them; phase timing is checked inline.
module tb_ttm4_mem_arbiter;
    import ttm4_mem_pkg::*;

    typedef struct packed {
        logic        loader;
        logic        rd;
        logic [14:0] data;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic        F_REQ, L_REQ, L_WE;
    logic [7:0]  F_ADD, L_ADD, ADD;
    logic [14:0] L_WDATA, F_RDATA, L_RDATA, WDATA, RDATA;
    logic        F_ACK, L_ACK, nOE, nWE, WDATA_OE, BUSY, GRANT;

    logic        d5_f_req;
    logic [7:0]  d5_f_add, d5_add;
    logic [14:0] d5_f_rdata, d5_l_rdata, d5_wdata, d5_rdata;
    logic        d5_f_ack, d5_l_ack, d5_noe, d5_nwe, d5_wdata_oe, d5_busy, d5_grant;

    logic [14:0] mem  [256];
    logic [14:0] mem5 [256];
    exp_t        exp_q [$];
    int          checks = 0;
    int          errors = 0;

    always #5 CLK = ~CLK;

    ttm4_mem_arbiter u_dut (
        .CLK(CLK), .RST(RST),
        .F_REQ(F_REQ), .F_ADD(F_ADD), .F_ACK(F_ACK), .F_RDATA(F_RDATA),
        .L_REQ(L_REQ), .L_WE(L_WE), .L_ADD(L_ADD), .L_WDATA(L_WDATA),
        .L_ACK(L_ACK), .L_RDATA(L_RDATA),
        .nOE(nOE), .nWE(nWE), .ADD(ADD), .WDATA(WDATA), .WDATA_OE(WDATA_OE),
        .RDATA(RDATA), .BUSY(BUSY), .GRANT(GRANT)
    );

    ttm4_mem_arbiter #(.SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(1)) u_dut5 (
        .CLK(CLK), .RST(RST),
        .F_REQ(d5_f_req), .F_ADD(d5_f_add), .F_ACK(d5_f_ack), .F_RDATA(d5_f_rdata),
        .L_REQ(1'b0), .L_WE(1'b0), .L_ADD(8'h00), .L_WDATA(15'h0000),
        .L_ACK(d5_l_ack), .L_RDATA(d5_l_rdata),
        .nOE(d5_noe), .nWE(d5_nwe), .ADD(d5_add), .WDATA(d5_wdata), .WDATA_OE(d5_wdata_oe),
        .RDATA(d5_rdata), .BUSY(d5_busy), .GRANT(d5_grant)
    );

    // Asynchronous-read memory models; writes land while nWE is low.
    always @(posedge CLK) if (!nWE) mem[ADD] <= WDATA;
    assign RDATA    = nOE ? 15'h0000 : mem[ADD];
    assign d5_rdata = d5_noe ? 15'h0000 : mem5[d5_add];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic wait_ack(input int which, output int cyc, output int noe_lo, output int nwe_lo);
        bit done;
        done = 0; cyc = 0; noe_lo = 0; nwe_lo = 0;
        while (!done && cyc < 40) begin
            @(negedge CLK);
            cyc++;
            if (!nOE) noe_lo++;
            if (!nWE) nwe_lo++;
            if ((which != 1 && F_ACK) || (which != 0 && L_ACK)) done = 1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: no ACK within %0d cycles, required one", cyc);
        end
    endtask

    task automatic do_write(input logic [7:0] a, input logic [14:0] d);
        int cyc, noe_lo, nwe_lo;
        L_WE = 1'b1; L_ADD = a; L_WDATA = d; L_REQ = 1'b1;
        exp_q.push_back('{loader: 1'b1, rd: 1'b0, data: 15'h0000});
        wait_ack(1, cyc, noe_lo, nwe_lo);
        L_REQ = 1'b0;
        check("wr_latency", 32'(cyc), 3);
        check("wr_nwe_cycles", 32'(nwe_lo), 1);
        check("wr_noe_cycles", 32'(noe_lo), 0);
        @(negedge CLK);
    endtask

    // Monitor: every ACK must match the oldest pending expectation.
    always @(negedge CLK) begin
        exp_t e;
        if (!RST) begin
            check("strobes_exclusive", 32'(nOE | nWE), 1);
            if (F_ACK || L_ACK) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: F_ACK=%0b L_ACK=%0b, required none", F_ACK, L_ACK);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_owner", 32'(L_ACK), 32'(e.loader));
                    check("ack_single", 32'(F_ACK & L_ACK), 0);
                    if (e.rd) check("ack_rdata", L_ACK ? 32'(L_RDATA) : 32'(F_RDATA), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc, noe_lo, nwe_lo;
        RST = 1'b1; F_REQ = 1'b0; F_ADD = '0; L_REQ = 1'b0; L_WE = 1'b0;
        L_ADD = '0; L_WDATA = '0; d5_f_req = 1'b0; d5_f_add = '0;
        mem5[8'h33] = ttm4_word(5'h12, 3'h5, 3'h2, 4'hA);
        repeat (2) @(negedge CLK);

        // Reset values
        check("rst_noe", 32'(nOE), 1);
        check("rst_nwe", 32'(nWE), 1);
        check("rst_add", 32'(ADD), 0);
        check("rst_wdata", 32'(WDATA), 0);
        check("rst_wdata_oe", 32'(WDATA_OE), 0);
        check("rst_acks", 32'({F_ACK, L_ACK}), 0);
        check("rst_rdata", 32'({F_RDATA, L_RDATA}), 0);
        check("rst_busy", 32'(BUSY), 0);
        check("rst_grant", 32'(GRANT), 0);
        RST = 1'b0;

        // Loader write to @00, per-cycle strobe timing
        L_WE = 1'b1; L_ADD = 8'h00; L_WDATA = 15'h0F00; L_REQ = 1'b1;
        exp_q.push_back('{loader: 1'b1, rd: 1'b0, data: 15'h0000});
        for (int c = 1; c <= 4; c++) begin
            @(negedge CLK);
            check("t1_nwe", 32'(nWE), (c == 2) ? 0 : 1);
            check("t1_noe", 32'(nOE), 1);
            check("t1_wdata_oe", 32'(WDATA_OE), 32'(c <= 3));
            check("t1_lack", 32'(L_ACK), 32'(c == 3));
            check("t1_busy", 32'(BUSY), 32'(c <= 3));
            if (c == 2) begin
                check("t1_wdata", 32'(WDATA), 32'h0F00);
                check("t1_add", 32'(ADD), 0);
                check("t1_grant", 32'(GRANT), 1);
            end
            if (c == 3) L_REQ = 1'b0;
        end

        // Two more writes, then back-to-back fetches of 00/01/02
        do_write(8'h01, 15'h00F0);
        do_write(8'h02, 15'h000F);
        exp_q.push_back('{loader: 1'b0, rd: 1'b1, data: 15'h0F00});
        exp_q.push_back('{loader: 1'b0, rd: 1'b1, data: 15'h00F0});
        exp_q.push_back('{loader: 1'b0, rd: 1'b1, data: 15'h000F});
        F_ADD = 8'h00; F_REQ = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_ack(0, cyc, noe_lo, nwe_lo);
            check("t2_ack_spacing", 32'(cyc), (i == 0) ? 3 : 4);
            check("t2_noe_cycles", 32'(noe_lo), 1);
            if (i < 2) F_ADD = 8'(i + 1);
            else       F_REQ = 1'b0;
        end
        @(negedge CLK);

        // Both requesters held from the first cycle after reset
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        F_ADD = 8'h01; F_REQ = 1'b1;
        L_WE = 1'b0; L_ADD = 8'h02; L_REQ = 1'b1;
        for (int i = 0; i < 4; i++)
            exp_q.push_back('{loader: 1'(i & 1), rd: 1'b1, data: (i & 1) ? 15'h000F : 15'h00F0});
        for (int i = 0; i < 4; i++) begin
            wait_ack(2, cyc, noe_lo, nwe_lo);
            check("t3_grant", 32'(GRANT), 32'(i & 1));
            check("t3_f_ack", 32'(F_ACK), 32'((i & 1) == 0));
            check("t3_l_ack", 32'(L_ACK), 32'((i & 1) == 1));
            check("t3_spacing", 32'(cyc), (i == 0) ? 3 : 4);
        end
        F_REQ = 1'b0; L_REQ = 1'b0;
        @(negedge CLK);

        // Reset during the STROBE cycle of a write abandons it
        L_WE = 1'b1; L_ADD = 8'h05; L_WDATA = ttm4_word(5'h1F, 3'h0, 3'h7, 4'h0); L_REQ = 1'b1;
        @(negedge CLK);
        check("t4_busy", 32'(BUSY), 1);
        check("t4_grant", 32'(GRANT), 1);
        @(negedge CLK);
        check("t4_strobe", 32'(nWE), 0);
        RST = 1'b1;
        @(negedge CLK);
        check("t4_nwe", 32'(nWE), 1);
        check("t4_wdata_oe", 32'(WDATA_OE), 0);
        check("t4_busy_rst", 32'(BUSY), 0);
        check("t4_grant_rst", 32'(GRANT), 0);
        check("t4_no_ack", 32'(L_ACK), 0);
        RST = 1'b0; L_REQ = 1'b0;
        repeat (6) @(negedge CLK);

        // Loader read of @01 with REQ dropped during SETUP
        L_WE = 1'b0; L_ADD = 8'h01; L_REQ = 1'b1;
        exp_q.push_back('{loader: 1'b1, rd: 1'b1, data: 15'h00F0});
        @(negedge CLK);
        check("t6_busy", 32'(BUSY), 1);
        L_REQ = 1'b0;
        wait_ack(1, cyc, noe_lo, nwe_lo);
        check("t6_latency", 32'(cyc), 2);
        check("t6_rdata", 32'(L_RDATA), 32'h00F0);
        @(negedge CLK);

        // Stretched timing instance: SETUP=2, STROBE=3, HOLD=1
        d5_f_add = 8'h33; d5_f_req = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge CLK);
            check("t5_noe", 32'(d5_noe), (i >= 3 && i <= 5) ? 0 : 1);
            check("t5_nwe", 32'(d5_nwe), 1);
            check("t5_f_ack", 32'(d5_f_ack), 32'(i == 6));
            check("t5_busy", 32'(d5_busy), 32'(i <= 6));
            check("t5_side", 32'({d5_l_ack, d5_wdata_oe, d5_grant}), 0);
            if (i <= 6) check("t5_add", 32'(d5_add), 32'h33);
            if (i == 6) begin
                check("t5_rdata", 32'(d5_f_rdata), 32'h4AAA);
                d5_f_req = 1'b0;
            end
        end
        check("t5_quiet", 32'({d5_wdata, d5_l_rdata}), 0);

        check("queue_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
